// File: rtl/branch_resolve_unit_pkg.sv
// rtl/branch_resolve_unit_pkg.sv - shared constants and types for the execute-stage branch unit
//
// Purpose: RV32I branch condition codes, the sequential PC increment and the
//          registered resolve-result record used by branch_resolve_unit.
// Ports:   none (package).
package branch_resolve_unit_pkg;

    localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
    localparam logic [2:0] FUNCT3_BNE  = 3'b001;
    localparam logic [2:0] FUNCT3_BLT  = 3'b100;
    localparam logic [2:0] FUNCT3_BGE  = 3'b101;
    localparam logic [2:0] FUNCT3_BLTU = 3'b110;
    localparam logic [2:0] FUNCT3_BGEU = 3'b111;

    localparam int unsigned PC_INCR = 4;

    // Packages cannot be parameterised, so the redirect field is sized for the
    // widest supported PC and the top zero-extends / truncates at its boundary.
    localparam int unsigned MAX_ADDR_WIDTH = 64;

    typedef struct packed {
        logic                      valid;
        logic                      taken;
        logic                      mispredict;
        logic [MAX_ADDR_WIDTH-1:0] redirect_pc;
    } resolve_t;

endpackage

// File: rtl/branch_resolve_unit_bht_counter_array.sv
// rtl/branch_resolve_unit_bht_counter_array.sv - branch history table of saturating counters
//
// Purpose: counter storage with a combinational prediction read port and a
//          saturating increment/decrement update port. All counters reset to
//          weakly not-taken. Reads see the pre-update value (no bypass).
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   rd_idx_i      lookup index;  rd_taken_o  MSB of the indexed counter
//   wr_en_i       update strobe; wr_idx_i    index to update
//   wr_taken_i    1 = increment, 0 = decrement
module bht_counter_array #(
    parameter int ENTRIES  = 64,
    parameter int CTR_BITS = 2,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_taken_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_taken_i
);

    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

    logic [CTR_BITS-1:0] ctr_q [ENTRIES];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_INIT;
            end
        end else if (wr_en_i) begin
            if (wr_taken_i && (ctr_q[wr_idx_i] != CTR_MAX)) begin
                ctr_q[wr_idx_i] <= ctr_q[wr_idx_i] + 1'b1;
            end else if (!wr_taken_i && (ctr_q[wr_idx_i] != '0)) begin
                ctr_q[wr_idx_i] <= ctr_q[wr_idx_i] - 1'b1;
            end
        end
    end

    assign rd_taken_o = ctr_q[rd_idx_i][CTR_BITS-1];

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - execute-stage branch resolve, predictor table and perf counters
//
// Purpose: evaluates the six RV32I branch conditions, computes the redirect PC,
//          compares against the fetch-time prediction and registers the outcome
//          for one cycle. Owns the BHT read by fetch and saturating counters of
//          resolved and mispredicted branches.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   fetch_pc_i              fetch PC for BHT lookup; fetch_pred_taken_o its prediction
//   valid_i, flush_i        instruction present / kill it (flush wins)
//   Branch_i, funct3_i      conditional branch and its condition code
//   operand1_i, operand2_i  rs1 / rs2 values
//   pc_i, imm_i             branch PC and sign-extended B-immediate
//   pred_taken_i            prediction carried from fetch
//   resolve_valid_o, branch_taken_o, mispredict_o, redirect_pc_o   registered outcome
//   branch_count_o, mispredict_count_o                             saturating perf counters
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CTR_BITS    = 2,
    parameter int PERF_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] fetch_pc_i,
    output logic                  fetch_pred_taken_o,
    input  logic                  valid_i,
    input  logic                  flush_i,
    input  logic                  Branch_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] operand1_i,
    input  logic [DATA_WIDTH-1:0] operand2_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic [ADDR_WIDTH-1:0] imm_i,
    input  logic                  pred_taken_i,
    output logic                  resolve_valid_o,
    output logic                  branch_taken_o,
    output logic                  mispredict_o,
    output logic [ADDR_WIDTH-1:0] redirect_pc_o,
    output logic [PERF_WIDTH-1:0] branch_count_o,
    output logic [PERF_WIDTH-1:0] mispredict_count_o
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic                  acc;
    logic                  legal;
    logic                  cond_taken;
    logic                  upd;
    logic                  mispred;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] fallthrough;
    logic [ADDR_WIDTH-1:0] next_pc;
    resolve_t              res_q;
    logic [PERF_WIDTH-1:0] branch_count_q;
    logic [PERF_WIDTH-1:0] mispredict_count_q;

    assign acc = valid_i & Branch_i & ~flush_i;

    always_comb begin
        cond_taken = 1'b0;
        legal      = 1'b1;
        case (funct3_i)
            FUNCT3_BEQ:  cond_taken = (operand1_i == operand2_i);
            FUNCT3_BNE:  cond_taken = (operand1_i != operand2_i);
            FUNCT3_BLT:  cond_taken = ($signed(operand1_i) <  $signed(operand2_i));
            FUNCT3_BGE:  cond_taken = ($signed(operand1_i) >= $signed(operand2_i));
            FUNCT3_BLTU: cond_taken = (operand1_i <  operand2_i);
            FUNCT3_BGEU: cond_taken = (operand1_i >= operand2_i);
            default:     legal      = 1'b0;
        endcase
    end

    // Both sums wrap modulo 2^ADDR_WIDTH by construction.
    assign target      = pc_i + imm_i;
    assign fallthrough = pc_i + ADDR_WIDTH'(PC_INCR);
    assign next_pc     = cond_taken ? target : fallthrough;
    assign mispred     = cond_taken ^ pred_taken_i;

    // Illegal encodings still strobe (as not-taken) but must not train or count.
    assign upd = acc & legal;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            res_q <= '0;
        end else begin
            res_q.valid      <= acc;
            res_q.taken      <= acc & cond_taken;
            res_q.mispredict <= acc & mispred;
            if (acc) begin
                res_q.redirect_pc <= MAX_ADDR_WIDTH'(next_pc);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else if (upd) begin
            if (branch_count_q != '1) begin
                branch_count_q <= branch_count_q + 1'b1;
            end
            if (mispred && (mispredict_count_q != '1)) begin
                mispredict_count_q <= mispredict_count_q + 1'b1;
            end
        end
    end

    bht_counter_array #(
        .ENTRIES  (BHT_ENTRIES),
        .CTR_BITS (CTR_BITS)
    ) u_bht (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rd_idx_i   (fetch_pc_i[IDX_W+1:2]),
        .rd_taken_o (fetch_pred_taken_o),
        .wr_en_i    (upd),
        .wr_idx_i   (pc_i[IDX_W+1:2]),
        .wr_taken_i (cond_taken)
    );

    // Only the index bits of the fetch PC and the low ADDR_WIDTH bits of the
    // stored redirect are meaningful; fold the rest away.
    logic unused_bits;
    assign unused_bits = ^{fetch_pc_i, res_q.redirect_pc};

    assign resolve_valid_o    = res_q.valid;
    assign branch_taken_o     = res_q.taken;
    assign mispredict_o       = res_q.mispredict;
    assign redirect_pc_o      = res_q.redirect_pc[ADDR_WIDTH-1:0];
    assign branch_count_o     = branch_count_q;
    assign mispredict_count_o = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        valid;
    logic        flush;
    logic        branch;
    logic [2:0]  funct3;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pred;

    logic        fpred;
    logic        rv;
    logic        tk;
    logic        mp;
    logic [31:0] rpc;
    logic [31:0] bc;
    logic [31:0] mc;

    logic        fpred4;
    logic        rv4;
    logic        tk4;
    logic        mp4;
    logic [31:0] rpc4;
    logic [3:0]  bc4;
    logic [3:0]  mc4;

    int num_checks = 0;
    int num_errors = 0;

    int exp_bc = 0;
    int exp_mc = 0;

    branch_resolve_unit dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .fetch_pc_i         (fetch_pc),
        .fetch_pred_taken_o (fpred),
        .valid_i            (valid),
        .flush_i            (flush),
        .Branch_i           (branch),
        .funct3_i           (funct3),
        .operand1_i         (op1),
        .operand2_i         (op2),
        .pc_i               (pc),
        .imm_i              (imm),
        .pred_taken_i       (pred),
        .resolve_valid_o    (rv),
        .branch_taken_o     (tk),
        .mispredict_o       (mp),
        .redirect_pc_o      (rpc),
        .branch_count_o     (bc),
        .mispredict_count_o (mc)
    );

    branch_resolve_unit #(.PERF_WIDTH(4)) dut4 (
        .clk_i              (clk),
        .rst_i              (rst),
        .fetch_pc_i         (fetch_pc),
        .fetch_pred_taken_o (fpred4),
        .valid_i            (valid),
        .flush_i            (flush),
        .Branch_i           (branch),
        .funct3_i           (funct3),
        .operand1_i         (op1),
        .operand2_i         (op2),
        .pc_i               (pc),
        .imm_i              (imm),
        .pred_taken_i       (pred),
        .resolve_valid_o    (rv4),
        .branch_taken_o     (tk4),
        .mispredict_o       (mp4),
        .redirect_pc_o      (rpc4),
        .branch_count_o     (bc4),
        .mispredict_count_o (mc4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic v, input logic fl, input logic br, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [31:0] im, input logic pr);
        valid  = v;
        flush  = fl;
        branch = br;
        funct3 = f3;
        op1    = a;
        op2    = b;
        pc     = p;
        imm    = im;
        pred   = pr;
        @(posedge clk);
        #1;
        valid  = 1'b0;
        flush  = 1'b0;
        branch = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic v, input logic t, input logic m,
                             input logic [31:0] r);
        check({tag, ".valid"}, 32'(rv), 32'(v));
        check({tag, ".taken"}, 32'(tk), 32'(t));
        check({tag, ".mispredict"}, 32'(mp), 32'(m));
        if (v) check({tag, ".redirect"}, rpc, r);
        check({tag, ".branch_count"}, bc, 32'(exp_bc));
        check({tag, ".mispredict_count"}, mc, 32'(exp_mc));
    endtask

    initial begin
        rst = 1'b1;
        fetch_pc = 32'h100;
        valid = 0; flush = 0; branch = 0; funct3 = 0;
        op1 = 0; op2 = 0; pc = 0; imm = 0; pred = 0;
        #12;
        check("reset.fetch_pred", 32'(fpred), 32'd0);
        check_out("reset", 1'b0, 1'b0, 1'b0, 32'h0);
        check("reset.redirect", rpc, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_out("idle", 1'b0, 1'b0, 1'b0, 32'h0);

        // BEQ taken, predicted not-taken
        issue(1, 0, 1, 3'b000, 32'd5, 32'd5, 32'h1000, 32'h20, 0);
        exp_bc = 1; exp_mc = 1;
        check_out("beq", 1, 1, 1, 32'h1020);

        // signed vs unsigned less-than on the same operands
        issue(1, 0, 1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h2000, 32'h10, 1);
        exp_bc = 2;
        check_out("blt", 1, 1, 0, 32'h2010);
        issue(1, 0, 1, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h2000, 32'h10, 1);
        exp_bc = 3; exp_mc = 2;
        check_out("bltu", 1, 0, 1, 32'h2004);

        // BHT training at pc 0x40 (index 16), initially weakly not-taken
        fetch_pc = 32'h40;
        #1;
        check("bht.init", 32'(fpred), 32'd0);
        issue(1, 0, 1, 3'b001, 32'd1, 32'd2, 32'h40, 32'h100, 0);
        exp_bc = 4; exp_mc = 3;
        check_out("bne", 1, 1, 1, 32'h140);
        check("bht.ctr2", 32'(fpred), 32'd1);
        issue(1, 0, 1, 3'b101, 32'd3, 32'd3, 32'h40, 32'h100, 1);
        exp_bc = 5;
        check_out("bge", 1, 1, 0, 32'h140);
        issue(1, 0, 1, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h100, 1);
        exp_bc = 6;
        check_out("bgeu", 1, 1, 0, 32'h140);
        check("bht.sat", 32'(fpred), 32'd1);
        issue(1, 0, 1, 3'b000, 32'd1, 32'd2, 32'h40, 32'h100, 1);
        exp_bc = 7; exp_mc = 4;
        check_out("beq_nt", 1, 0, 1, 32'h44);
        check("bht.ctr2_after_sat", 32'(fpred), 32'd1);
        issue(1, 0, 1, 3'b100, 32'd5, 32'hFFFF_FFFD, 32'h40, 32'h100, 0);
        exp_bc = 8;
        check_out("blt_nt", 1, 0, 0, 32'h44);
        check("bht.ctr1", 32'(fpred), 32'd0);

        // flushed instruction: nothing happens
        issue(1, 1, 1, 3'b000, 32'd5, 32'd5, 32'h40, 32'h100, 1);
        check_out("flush", 0, 0, 0, 32'h0);
        check("flush.bht", 32'(fpred), 32'd0);

        // not a branch
        issue(1, 0, 0, 3'b000, 32'd5, 32'd5, 32'h40, 32'h100, 1);
        check_out("nobranch", 0, 0, 0, 32'h0);

        // illegal funct3: strobe, not-taken, no training or counting
        issue(1, 0, 1, 3'b010, 32'd5, 32'd5, 32'h40, 32'h100, 1);
        check_out("illegal", 1, 0, 1, 32'h44);
        check("illegal.bht", 32'(fpred), 32'd0);
        issue(1, 0, 1, 3'b000, 32'd5, 32'd5, 32'h40, 32'h100, 0);
        exp_bc = 9; exp_mc = 5;
        check_out("after_illegal", 1, 1, 1, 32'h140);
        check("illegal.no_train", 32'(fpred), 32'd1);

        // PC wrap-around on both target and fallthrough
        issue(1, 0, 1, 3'b000, 32'd7, 32'd7, 32'hFFFF_FFF0, 32'h20, 1);
        exp_bc = 10;
        check_out("wrap_target", 1, 1, 0, 32'h10);
        issue(1, 0, 1, 3'b001, 32'd7, 32'd7, 32'hFFFF_FFFC, 32'h20, 0);
        exp_bc = 11;
        check_out("wrap_fall", 1, 0, 0, 32'h0);

        // back-to-back taken mispredicts until the 4-bit counters saturate
        for (int i = 0; i < 6; i++) begin
            issue(1, 0, 1, 3'b000, 32'd1, 32'd1, 32'h80, 32'h8, 0);
            exp_bc++; exp_mc++;
            check_out("stream", 1, 1, 1, 32'h88);
        end
        check("perf4.branch_sat", 32'(bc4), 32'd15);
        check("perf4.mispredict", 32'(mc4), 32'd11);
        check("perf4.valid", 32'(rv4), 32'd1);
        issue(1, 0, 1, 3'b000, 32'd1, 32'd1, 32'h80, 32'h8, 1);
        exp_bc++;
        check_out("last", 1, 1, 0, 32'h88);
        check("perf4.branch_hold", 32'(bc4), 32'd15);
        check("perf4.mispredict_hold", 32'(mc4), 32'd11);

        @(posedge clk);
        #1;
        check_out("idle2", 0, 0, 0, 32'h0);

        // asynchronous reset mid-cycle, right after an accept registers
        fetch_pc = 32'h80;
        issue(1, 0, 1, 3'b000, 32'd1, 32'd1, 32'h80, 32'h8, 0);
        exp_bc++; exp_mc++;
        check_out("pre_reset", 1, 1, 1, 32'h88);
        check("pre_reset.fetch_pred", 32'(fpred), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        exp_bc = 0; exp_mc = 0;
        check_out("async_reset", 0, 0, 0, 32'h0);
        check("async_reset.redirect", rpc, 32'h0);
        check("async_reset.fetch_pred", 32'(fpred), 32'd0);
        check("async_reset.perf4", 32'(bc4), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_out("post_reset", 0, 0, 0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised execute-stage branch unit for the pipelined core. It replaces the purely combinational taken/not-taken compare.
- Evaluates all six RV32I branch conditions and computes the redirect PC.
- Checks the result against the prediction carried down the pipeline and registers the outcome for one cycle.
- Owns the BHT of saturating counters that fetch reads for its prediction, plus saturating branch and mispredict counters for performance monitoring.

Parameters:
- DATA_WIDTH, 32, operand width in bits.
- ADDR_WIDTH, 32, PC width in bits.
- BHT_ENTRIES, 64, number of predictor counters; power of two, at least 2.
- CTR_BITS, 2, width of each saturating predictor counter; at least 1.
- PERF_WIDTH, 32, width of each performance counter.

Ports:
- clk_i  in  1  clock; every register samples on the rising edge.
- rst_i  in  1  reset: asynchronous, active-high.
- fetch_pc_i  in  ADDR_WIDTH  PC being fetched; used for the BHT lookup.
- fetch_pred_taken_o  out  1  prediction for fetch_pc_i; combinational.
- valid_i  in  1  an execute-stage instruction is present.
- flush_i  in  1  kill the current execute-stage instruction.
- Branch_i  in  1  the instruction is a conditional branch.
- funct3_i  in  3  branch condition code.
- operand1_i  in  DATA_WIDTH  rs1 value.
- operand2_i  in  DATA_WIDTH  rs2 value.
- pc_i  in  ADDR_WIDTH  PC of the branch.
- imm_i  in  ADDR_WIDTH  sign-extended B-immediate.
- pred_taken_i  in  1  prediction made at fetch, carried down the pipeline.
- resolve_valid_o  out  1  registered one-cycle strobe: outcome fields are valid.
- branch_taken_o  out  1  registered resolved direction.
- mispredict_o  out  1  registered; resolved direction differs from pred_taken_i.
- redirect_pc_o  out  ADDR_WIDTH  registered; the correct next PC.
- branch_count_o  out  PERF_WIDTH  number of resolved legal branches.
- mispredict_count_o  out  PERF_WIDTH  number of mispredicted legal branches.

Behaviour:
- Reset (rst_i high, asynchronous):
  - resolve_valid_o, branch_taken_o, mispredict_o = 0; redirect_pc_o = 0.
  - Both performance counters = 0.
  - Every BHT counter = 2^(CTR_BITS-1)-1 (weakly not-taken; 01 for CTR_BITS=2).
  - Assertion mid-operation discards any in-flight outcome immediately.
- Accept condition: acc = valid_i & Branch_i & ~flush_i.
- Conditions, evaluated in the accept cycle:
  - BEQ: equal. BNE: not equal.
  - BLT / BGE: signed less-than / signed not-less-than.
  - BLTU / BGEU: unsigned less-than / unsigned not-less-than.
  - Comparisons are full DATA_WIDTH.
  - funct3 010 or 011 is illegal.
- Targets: target = pc_i + imm_i; fallthrough = pc_i + 4. Both are modulo 2^ADDR_WIDTH; wrap-around is allowed, with no exception.
- Latency: exactly 1 cycle. After an accept in cycle N, in cycle N+1:
  - resolve_valid_o = 1.
  - branch_taken_o = the condition result.
  - mispredict_o = taken ^ pred_taken_i.
  - redirect_pc_o = taken ? target : fallthrough.
- When acc = 0 in cycle N: resolve_valid_o = 0 in N+1, and branch_taken_o and mispredict_o are forced to 0 in N+1.
- Illegal funct3: taken = 0, so mispredict = pred_taken_i and redirect = fallthrough. The BHT is not updated and neither performance counter increments.
- Flush: flush_i has priority over valid_i. A flushed instruction produces no strobe, no BHT update and no counting. A strobe already registered is not retracted.
- BHT:
  - Index = pc[log2(BHT_ENTRIES)+1 : 2], for both fetch lookup and update.
  - Prediction = MSB of the indexed counter.
  - On a legal accept, the counter at pc_i's index updates at the clock edge: increment if taken, decrement if not. It saturates at 0 and at 2^CTR_BITS-1.
  - A lookup to the index being updated in the same cycle returns the old value; there is no bypass.
- Performance counters:
  - On a legal accept, branch_count_o increments; mispredict_count_o also increments if mispredicted.
  - Both saturate at all-ones and never wrap.
- Back-to-back accepts on every cycle are supported; there is no stall input. Each accept is an independent 1-cycle pipeline.

Decomposition:
- Shared package defines: FUNCT3_BEQ/BNE/BLT/BGE/BLTU/BGEU constants, a resolve-result struct (valid, taken, mispredict, redirect_pc), and the PC increment constant 4.
- One sub-module, bht_counter_array: holds the counter storage, combinational read port, saturating update port and reset initialisation.
- Compare, target and performance logic stay in the top module.

Test Plan:
- After reset: fetch lookup at PC 0x100 -> fetch_pred_taken_o=0; all outputs 0; both counters 0.
- BEQ with op1=op2=5, pc=0x1000, imm=0x20, pred=0 -> next cycle: valid=1, taken=1, mispredict=1, redirect=0x1020; branch_count=1, mispredict_count=1.
- BLT op1=0xFFFFFFFF, op2=1 -> taken=1. BLTU with the same operands -> taken=0, redirect=pc+4.
- Three taken branches at pc 0x40 -> counter saturates at 3 (stays 3), fetch prediction 1. Then one not-taken -> counter 2, prediction still 1.
- valid_i=1 with flush_i=1 -> no strobe, counters and BHT unchanged. funct3=010 with pred=1 -> strobe, taken=0, mispredict=1, counters unchanged.
- PERF_WIDTH=4 build, 17 legal branches -> branch_count_o holds at 15. Reset asserted mid-stream between a clock edge -> outputs clear immediately, without waiting for the clock.
